// File: rtl/cvxif_mem_adapter_pkg.sv
// cvxif_mem_adapter_pkg: shared types, exception codes and byte-enable helpers
// for the CV-X-IF to dcache adapter.
package cvxif_mem_adapter_pkg;

    localparam logic [5:0] EXC_LD_MISALIGNED = 6'd4;
    localparam logic [5:0] EXC_ST_MISALIGNED = 6'd6;

    localparam int unsigned X_ID_W         = 4;
    localparam int unsigned DCACHE_INDEX_W = 12;
    localparam int unsigned DCACHE_TAG_W   = 20;
    localparam int unsigned DCACHE_DATA_W  = 32;
    localparam int unsigned DCACHE_TID_W   = 4;

    typedef struct packed {
        logic [X_ID_W-1:0] id;
        logic              we;
    } meta_entry_t;

    typedef struct packed {
        logic [DCACHE_INDEX_W-1:0]  address_index;
        logic [DCACHE_TAG_W-1:0]    address_tag;
        logic [DCACHE_DATA_W-1:0]   data_wdata;
        logic                       data_req;
        logic                       data_we;
        logic [DCACHE_DATA_W/8-1:0] data_be;
        logic [1:0]                 data_size;
        logic [DCACHE_TID_W-1:0]    data_id;
        logic                       kill_req;
        logic                       tag_valid;
    } dcache_req_t;

    typedef struct packed {
        logic                     data_gnt;
        logic                     data_rvalid;
        logic [DCACHE_DATA_W-1:0] data_rdata;
    } dcache_rsp_t;

    // A legal mask is one contiguous run of 1/2/4/8 bytes aligned to its own length.
    function automatic logic be_legal(input logic [7:0] be);
        logic ok;
        ok = 1'b0;
        for (int n = 1; n <= 8; n = n * 2)
            for (int s = 0; s + n <= 8; s = s + n)
                ok = ok | (be == 8'(((1 << n) - 1) << s));
        return ok;
    endfunction

    function automatic logic [1:0] be_to_size(input logic [7:0] be);
        int c;
        c = $countones(be);
        return c >= 8 ? 2'd3 : c >= 4 ? 2'd2 : c >= 2 ? 2'd1 : 2'd0;
    endfunction

endpackage

// File: rtl/cvxif_adapter_fifo.sv
// cvxif_adapter_fifo: synchronous FIFO with registered count; Depth must be a
// power of two so the pointers wrap naturally.
module cvxif_adapter_fifo #(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = 4,
    localparam int unsigned PtrW = $clog2(Depth),
    localparam int unsigned CntW = PtrW + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] data_i,
    input  logic             pop_i,
    output logic [Width-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CntW-1:0]  count_o,
    output logic [PtrW-1:0]  wptr_o
);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             do_push, do_pop;

    always_comb begin
        full_o  = cnt_q == CntW'(Depth);
        empty_o = cnt_q == '0;
        do_push = push_i && !full_o;
        do_pop  = pop_i && !empty_o;
        wptr_d  = wptr_q + PtrW'(do_push);
        rptr_d  = rptr_q + PtrW'(do_pop);
        cnt_d   = cnt_q + CntW'(do_push) - CntW'(do_pop);
        data_o  = mem_q[rptr_q];
        count_o = cnt_q;
        wptr_o  = wptr_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= data_i;
    end

endmodule

// File: rtl/cvxif_dcache_adapter_mo.sv
// cvxif_dcache_adapter_mo: multi-outstanding CV-X-IF memory bridge onto one dcache
// port, retiring results strictly in acceptance order.
module cvxif_dcache_adapter_mo
    import cvxif_mem_adapter_pkg::*;
#(
    parameter int unsigned NrOutstanding = 4,
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned IdWidth       = 4,
    parameter int unsigned IndexWidth    = 12,
    parameter int unsigned TagWidth      = AddrWidth - IndexWidth,
    parameter type dcache_req_t = cvxif_mem_adapter_pkg::dcache_req_t,
    parameter type dcache_rsp_t = cvxif_mem_adapter_pkg::dcache_rsp_t,
    localparam int unsigned BeWidth = DataWidth / 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 x_mem_valid_i,
    output logic                 x_mem_ready_o,
    input  logic [AddrWidth-1:0] x_mem_addr_i,
    input  logic                 x_mem_we_i,
    input  logic [BeWidth-1:0]   x_mem_be_i,
    input  logic [DataWidth-1:0] x_mem_wdata_i,
    input  logic [IdWidth-1:0]   x_mem_id_i,
    output logic                 x_mem_exc_o,
    output logic [5:0]           x_mem_exccode_o,
    output logic                 x_mem_result_valid_o,
    output logic [IdWidth-1:0]   x_mem_result_id_o,
    output logic [DataWidth-1:0] x_mem_result_rdata_o,
    output logic                 x_mem_result_err_o,
    output dcache_req_t          dcache_req_o,
    input  dcache_rsp_t          dcache_rsp_i
);

    localparam int unsigned PtrW = $clog2(NrOutstanding);
    localparam int unsigned CntW = PtrW + 1;

    logic                 tag_pending_q, tag_pending_d;
    logic [TagWidth-1:0]  tag_q, tag_d;
    logic                 legal, can_issue, gnt, retire, head_load, bypass;
    meta_entry_t          meta_in, meta_head;
    logic                 meta_full, meta_empty;
    logic [CntW-1:0]      meta_cnt;
    logic [PtrW-1:0]      meta_wptr;
    logic [DataWidth-1:0] rd_head;
    logic                 rd_full, rd_empty;
    logic [CntW-1:0]      rd_cnt;
    logic [PtrW-1:0]      rd_wptr;
    logic                 unused;

    assign unused = ^{meta_cnt, rd_full, rd_cnt, rd_wptr};

    always_comb begin
        legal     = be_legal(8'(x_mem_be_i));
        // Stores present their tag immediately, so they wait while a load tag occupies the port.
        can_issue = x_mem_valid_i && legal && !meta_full && !(x_mem_we_i && tag_pending_q);
        gnt       = can_issue && dcache_rsp_i.data_gnt;
        x_mem_exc_o     = x_mem_valid_i && !legal;
        x_mem_ready_o   = x_mem_exc_o || gnt;
        x_mem_exccode_o = x_mem_exc_o ? (x_mem_we_i ? EXC_ST_MISALIGNED : EXC_LD_MISALIGNED) : '0;
        tag_pending_d = gnt && !x_mem_we_i;
        tag_d         = tag_pending_d ? x_mem_addr_i[AddrWidth-1:IndexWidth] : tag_q;
        dcache_req_o               = '0;
        dcache_req_o.data_req      = can_issue;
        dcache_req_o.data_we       = can_issue && x_mem_we_i;
        dcache_req_o.address_index = can_issue ? x_mem_addr_i[IndexWidth-1:0] : '0;
        dcache_req_o.address_tag   = (can_issue && x_mem_we_i) ? x_mem_addr_i[AddrWidth-1:IndexWidth] : tag_q;
        dcache_req_o.tag_valid     = tag_pending_q;
        dcache_req_o.data_be       = can_issue ? x_mem_be_i : '0;
        dcache_req_o.data_wdata    = can_issue ? x_mem_wdata_i : '0;
        dcache_req_o.data_size     = can_issue ? be_to_size(8'(x_mem_be_i)) : '0;
        dcache_req_o.data_id[PtrW-1:0] = can_issue ? meta_wptr : '0;
        meta_in   = '{id: x_mem_id_i, we: x_mem_we_i};
        head_load = !meta_empty && !meta_head.we;
        bypass    = head_load && rd_empty && dcache_rsp_i.data_rvalid;
        retire    = !meta_empty && (meta_head.we || !rd_empty || dcache_rsp_i.data_rvalid);
        x_mem_result_valid_o = retire;
        x_mem_result_id_o    = retire ? meta_head.id : '0;
        x_mem_result_rdata_o = (retire && head_load) ? (rd_empty ? dcache_rsp_i.data_rdata : rd_head) : '0;
        x_mem_result_err_o   = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tag_pending_q <= 1'b0;
            tag_q         <= '0;
        end else begin
            tag_pending_q <= tag_pending_d;
            tag_q         <= tag_d;
        end
    end

    cvxif_adapter_fifo #(
        .Width ($bits(meta_entry_t)),
        .Depth (NrOutstanding)
    ) i_meta_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (gnt),
        .data_i  (meta_in),
        .pop_i   (retire),
        .data_o  (meta_head),
        .full_o  (meta_full),
        .empty_o (meta_empty),
        .count_o (meta_cnt),
        .wptr_o  (meta_wptr)
    );

    cvxif_adapter_fifo #(
        .Width (DataWidth),
        .Depth (NrOutstanding)
    ) i_rdata_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (dcache_rsp_i.data_rvalid && !bypass),
        .data_i  (dcache_rsp_i.data_rdata),
        .pop_i   (retire && head_load && !rd_empty),
        .data_o  (rd_head),
        .full_o  (rd_full),
        .empty_o (rd_empty),
        .count_o (rd_cnt),
        .wptr_o  (rd_wptr)
    );

endmodule

// File: tb/tb_cvxif_dcache_adapter_mo.sv
// tb_cvxif_dcache_adapter_mo: alignment vector table plus directed ordering,
// back-pressure and reset sequences against a hand-driven dcache.
module tb_cvxif_dcache_adapter_mo;
    import cvxif_mem_adapter_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        valid, we, ready, exc, res_valid, res_err;
    logic [31:0] addr, wdata, res_rdata;
    logic [3:0]  be, id, res_id;
    logic [5:0]  exccode;
    dcache_req_t req;
    dcache_rsp_t rsp;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic        exp_ready;
        logic        exp_exc;
        logic [5:0]  exp_code;
        logic        exp_req;
        logic [1:0]  exp_size;
        logic [11:0] exp_index;
        logic [19:0] exp_tag;
    } vec_t;

    vec_t tbl [10];

    always #5 clk = ~clk;

    cvxif_dcache_adapter_mo dut (
        .clk_i                (clk),
        .rst_i                (rst),
        .x_mem_valid_i        (valid),
        .x_mem_ready_o        (ready),
        .x_mem_addr_i         (addr),
        .x_mem_we_i           (we),
        .x_mem_be_i           (be),
        .x_mem_wdata_i        (wdata),
        .x_mem_id_i           (id),
        .x_mem_exc_o          (exc),
        .x_mem_exccode_o      (exccode),
        .x_mem_result_valid_o (res_valid),
        .x_mem_result_id_o    (res_id),
        .x_mem_result_rdata_o (res_rdata),
        .x_mem_result_err_o   (res_err),
        .dcache_req_o         (req),
        .dcache_rsp_i         (rsp)
    );

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic w, input logic [3:0] b,
                         input logic [31:0] d, input logic [3:0] i);
        valid = v; addr = a; we = w; be = b; wdata = d; id = i;
    endtask

    task automatic resp(input logic g, input logic rv, input logic [31:0] rd);
        rsp.data_gnt = g; rsp.data_rvalid = rv; rsp.data_rdata = rd;
    endtask

    task automatic expect_res(input string n, input logic v, input logic [3:0] i, input logic [31:0] d);
        chk({n, "_valid"}, res_valid, v);
        if (v) begin
            chk({n, "_id"}, res_id, i);
            chk({n, "_rdata"}, res_rdata, d);
            chk({n, "_err"}, res_err, 0);
        end
    endtask

    initial begin
        tbl[0] = '{32'h1000_0104, 0, 4'hF, 0, 0, 6'd0, 1, 2'd2, 12'h104, 20'h0};
        tbl[1] = '{32'h2000_0008, 1, 4'h6, 1, 1, 6'd6, 0, 2'd0, 12'h000, 20'h0};
        tbl[2] = '{32'h1000_0002, 0, 4'hC, 0, 0, 6'd0, 1, 2'd1, 12'h002, 20'h0};
        tbl[3] = '{32'h0000_0041, 0, 4'h6, 1, 1, 6'd4, 0, 2'd0, 12'h000, 20'h0};
        tbl[4] = '{32'h4567_8ABC, 1, 4'h1, 0, 0, 6'd0, 1, 2'd0, 12'hABC, 20'h45678};
        tbl[5] = '{32'h0000_0000, 0, 4'h5, 1, 1, 6'd4, 0, 2'd0, 12'h000, 20'h0};
        tbl[6] = '{32'h0000_1FFF, 1, 4'h8, 0, 0, 6'd0, 1, 2'd0, 12'hFFF, 20'h00001};
        tbl[7] = '{32'h0000_0000, 0, 4'h0, 1, 1, 6'd4, 0, 2'd0, 12'h000, 20'h0};
        tbl[8] = '{32'hCAFE_0F00, 1, 4'h3, 0, 0, 6'd0, 1, 2'd1, 12'hF00, 20'hCAFE0};
        tbl[9] = '{32'h0000_0000, 1, 4'hE, 1, 1, 6'd6, 0, 2'd0, 12'h000, 20'h0};

        drive(0, 0, 0, 0, 0, 0);
        resp(0, 0, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_ready", ready, 0);
        chk("rst_exc", exc, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_data_req", req.data_req, 0);
        chk("rst_tag_valid", req.tag_valid, 0);

        // Alignment/issue decode with grant withheld, so nothing is ever enqueued.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(1, tbl[i].addr, tbl[i].we, tbl[i].be, 32'h0BAD_F00D, 4'(i));
            #1;
            chk($sformatf("v%0d_ready", i), ready, tbl[i].exp_ready);
            chk($sformatf("v%0d_exc", i), exc, tbl[i].exp_exc);
            chk($sformatf("v%0d_code", i), exccode, tbl[i].exp_code);
            chk($sformatf("v%0d_req", i), req.data_req, tbl[i].exp_req);
            chk($sformatf("v%0d_size", i), req.data_size, tbl[i].exp_size);
            chk($sformatf("v%0d_index", i), req.address_index, tbl[i].exp_index);
            chk($sformatf("v%0d_tag", i), req.address_tag, tbl[i].exp_tag);
            chk($sformatf("v%0d_res", i), res_valid, 0);
        end

        // Single load, data three cycles after grant.
        @(negedge clk);
        drive(1, 32'h1000_0104, 0, 4'hF, 0, 4'd5);
        resp(1, 0, 0);
        #1;
        chk("ld_ready", ready, 1);
        chk("ld_index", req.address_index, 12'h104);
        chk("ld_id", req.data_id, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        resp(0, 0, 0);
        #1;
        chk("ld_tag_valid", req.tag_valid, 1);
        chk("ld_tag", req.address_tag, 20'h10000);
        expect_res("ld_wait1", 0, 0, 0);
        @(negedge clk);
        #1;
        chk("ld_tag_valid_off", req.tag_valid, 0);
        expect_res("ld_wait2", 0, 0, 0);
        @(negedge clk);
        resp(0, 1, 32'hDEAD_BEEF);
        #1;
        expect_res("ld_res", 1, 4'd5, 32'hDEAD_BEEF);
        @(negedge clk);
        resp(0, 0, 0);
        #1;
        expect_res("ld_done", 0, 0, 0);

        // Four loads fill the queue, a fifth waits for the first retire.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive(1, 32'h0000_1000 + 32'(4 * k), 0, 4'hF, 0, 4'(k));
            resp(1, 0, 0);
            #1;
            chk($sformatf("b2b%0d_ready", k), ready, 1);
            chk($sformatf("b2b%0d_did", k), req.data_id, 4'((k + 1) % 4));
        end
        @(negedge clk);
        drive(1, 32'h0000_1010, 0, 4'hF, 0, 4'd4);
        #1;
        chk("full_ready", ready, 0);
        chk("full_req", req.data_req, 0);
        expect_res("full_nores", 0, 0, 0);
        @(negedge clk);
        resp(1, 1, 32'hA0);
        #1;
        chk("full_retire_ready", ready, 0);
        expect_res("b2b_r0", 1, 4'd0, 32'hA0);
        @(negedge clk);
        resp(1, 1, 32'hA1);
        #1;
        chk("fifth_ready", ready, 1);
        chk("fifth_did", req.data_id, 4'd1);
        expect_res("b2b_r1", 1, 4'd1, 32'hA1);
        for (int k = 2; k < 5; k++) begin
            @(negedge clk);
            drive(0, 0, 0, 0, 0, 0);
            resp(0, 1, 32'hA0 + 32'(k));
            #1;
            expect_res($sformatf("b2b_r%0d", k), 1, 4'(k), 32'hA0 + 32'(k));
        end
        @(negedge clk);
        resp(0, 0, 0);
        #1;
        expect_res("b2b_done", 0, 0, 0);

        // Load then store: one stall cycle, store result held behind the load.
        @(negedge clk);
        drive(1, 32'h2000_0010, 0, 4'hF, 0, 4'd7);
        resp(1, 0, 0);
        #1;
        chk("ls_ld_ready", ready, 1);
        @(negedge clk);
        drive(1, 32'h3000_0020, 1, 4'hF, 32'h1234, 4'd8);
        #1;
        chk("ls_st_stall", ready, 0);
        chk("ls_st_stall_req", req.data_req, 0);
        chk("ls_ld_tag", req.address_tag, 20'h20000);
        @(negedge clk);
        #1;
        chk("ls_st_ready", ready, 1);
        chk("ls_st_we", req.data_we, 1);
        chk("ls_st_tag", req.address_tag, 20'h30000);
        chk("ls_st_tagv", req.tag_valid, 0);
        chk("ls_st_wdata", req.data_wdata, 32'h1234);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        resp(0, 0, 0);
        #1;
        expect_res("ls_hold", 0, 0, 0);
        @(negedge clk);
        resp(0, 1, 32'h55);
        #1;
        expect_res("ls_ld_res", 1, 4'd7, 32'h55);
        @(negedge clk);
        resp(0, 0, 0);
        #1;
        expect_res("ls_st_res", 1, 4'd8, 32'h0);
        @(negedge clk);
        #1;
        expect_res("ls_done", 0, 0, 0);

        // Load, store, load, load: later load data is buffered behind the store.
        @(negedge clk);
        drive(1, 32'h0000_2000, 0, 4'hF, 0, 4'h9);
        resp(1, 0, 0);
        #1;
        chk("buf_l0_ready", ready, 1);
        @(negedge clk);
        drive(1, 32'h0000_3000, 1, 4'hF, 32'h77, 4'hA);
        #1;
        chk("buf_st_stall", ready, 0);
        @(negedge clk);
        #1;
        chk("buf_st_ready", ready, 1);
        @(negedge clk);
        drive(1, 32'h0000_2004, 0, 4'hF, 0, 4'hB);
        #1;
        chk("buf_l1_ready", ready, 1);
        @(negedge clk);
        drive(1, 32'h0000_2008, 0, 4'hF, 0, 4'hC);
        #1;
        chk("buf_l2_ready", ready, 1);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        resp(0, 0, 0);
        #1;
        expect_res("buf_wait", 0, 0, 0);
        @(negedge clk);
        resp(0, 1, 32'h100);
        #1;
        expect_res("buf_l0", 1, 4'h9, 32'h100);
        @(negedge clk);
        resp(0, 1, 32'h101);
        #1;
        expect_res("buf_st", 1, 4'hA, 32'h0);
        @(negedge clk);
        resp(0, 1, 32'h102);
        #1;
        expect_res("buf_l1", 1, 4'hB, 32'h101);
        @(negedge clk);
        resp(0, 0, 0);
        #1;
        expect_res("buf_l2", 1, 4'hC, 32'h102);
        @(negedge clk);
        #1;
        expect_res("buf_done", 0, 0, 0);

        // Reset with three loads in flight flushes everything.
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            drive(1, 32'h5000_0000 + 32'(4 * k), 0, 4'hF, 0, 4'(k));
            resp(1, 0, 0);
            #1;
            chk($sformatf("rf%0d_ready", k), ready, 1);
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        resp(0, 0, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        expect_res("rf_res", 0, 0, 0);
        chk("rf_tagv", req.tag_valid, 0);
        chk("rf_req", req.data_req, 0);
        drive(1, 32'h6000_0040, 0, 4'hF, 0, 4'hE);
        resp(1, 0, 0);
        #1;
        chk("rf_ready", ready, 1);
        chk("rf_did", req.data_id, 4'd0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        resp(0, 0, 0);
        #1;
        chk("rf_tag", req.address_tag, 20'h60000);
        expect_res("rf_wait", 0, 0, 0);
        @(negedge clk);
        resp(0, 1, 32'h77);
        #1;
        expect_res("rf_new", 1, 4'hE, 32'h77);
        @(negedge clk);
        resp(0, 0, 0);
        #1;
        expect_res("rf_done", 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
